// File: rtl/bitcount_datapath_if.sv
// bitcount_datapath_if: result read-out bundle of the bit-count datapath.
// master drives result/result_valid and samples result_ack; slave is the reader.
interface bitcount_datapath_if #(
    parameter int CW = 4
);
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ack;

    modport master (
        output result,
        output result_valid,
        input  result_ack
    );

    modport slave (
        input  result,
        input  result_valid,
        output result_ack
    );
endinterface

// File: rtl/bitcount_datapath.sv
// bitcount_datapath: operand shift register, ones counter and result capture.
// Ports: clk, reset (sync, active-low), data_in, loadA, enableA, loadResult,
//   enableResult, done in; A, count, overrun, err out; rif (master) carries
//   result/result_valid/result_ack. Optional BITCOUNT_HEX_DISPLAY_EN adds HEX0.
module bitcount_datapath #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             loadA,
    input  logic             enableA,
    input  logic             loadResult,
    input  logic             enableResult,
    input  logic             done,
    output logic [WIDTH-1:0] A,
    output logic [CW-1:0]    count,
    bitcount_datapath_if.master rif,
    output logic             overrun,
`ifdef BITCOUNT_HEX_DISPLAY_EN
    output logic             err,
    output logic [6:0]       HEX0
`else
    output logic             err
`endif
);

    localparam logic [CW-1:0] CMAX = CW'(WIDTH);

    logic done_q;
    logic capture;
    logic sat_hit;
    logic both_a;

    // Capture only on the rising edge of done, so a held done
    // produces a single result.
    assign capture = done & ~done_q;
    assign sat_hit = ~loadResult & enableResult & (count == CMAX);
    assign both_a  = loadA & enableA;

    // Operand shift register: load wins over shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            A <= '0;
        end else if (loadA) begin
            A <= data_in;
        end else if (enableA) begin
            A <= A >> 1;
        end
    end

    // Ones counter: clear wins over increment; saturates at WIDTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (loadResult) begin
            count <= '0;
        end else if (enableResult && count != CMAX) begin
            count <= count + CW'(1);
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (both_a || sat_hit) begin
            err <= 1'b1;
        end
    end

    // Result capture and valid/ack handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q           <= 1'b0;
            rif.result       <= '0;
            rif.result_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            done_q <= done;
            if (capture) begin
                rif.result       <= count;
                rif.result_valid <= 1'b1;
                // An ack in the same cycle consumes the old value.
                if (rif.result_valid && !rif.result_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rif.result_valid && rif.result_ack) begin
                rif.result_valid <= 1'b0;
            end
        end
    end

`ifdef BITCOUNT_HEX_DISPLAY_EN
    logic [6:0] seg;

    // Active-low segments, bit order gfedcba.
    always_comb begin
        seg = 7'b1111111;
        unique case (4'(rif.result))
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

    // Display lags result by one edge; blank while nothing is valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            HEX0 <= 7'b1000000;
        end else begin
            HEX0 <= rif.result_valid ? seg : 7'b1111111;
        end
    end
`endif

endmodule

// File: tb/tb_bitcount_datapath.sv
// tb_bitcount_datapath: directed stimulus with a per-cycle reference model
// and literal expectations for bitcount_datapath.
module tb_bitcount_datapath;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             loadA, enableA, loadResult, enableResult, done;
    logic [WIDTH-1:0] A;
    logic [CW-1:0]    count;
    logic             overrun, err;
`ifdef BITCOUNT_HEX_DISPLAY_EN
    logic [6:0]       HEX0;
`endif

    bitcount_datapath_if #(.CW(CW)) rif ();

    bitcount_datapath #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .loadA        (loadA),
        .enableA      (enableA),
        .loadResult   (loadResult),
        .enableResult (enableResult),
        .done         (done),
        .A            (A),
        .count        (count),
        .rif          (rif.master),
        .overrun      (overrun),
`ifdef BITCOUNT_HEX_DISPLAY_EN
        .err          (err),
        .HEX0         (HEX0)
`else
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model: state as plain integers, updated from spec rules.
    int m_A, m_count, m_result;
    bit m_valid, m_over, m_err, m_done_q;
    int m_hex;
    bit chk_en = 1'b0;

    function automatic int seg_of(input int v);
        int t [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                       'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
        return t[v];
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_A <= 0; m_count <= 0; m_result <= 0;
            m_valid <= 0; m_over <= 0; m_err <= 0; m_done_q <= 0;
            m_hex <= 'h40;
        end else begin
            if (loadA) m_A <= int'(data_in);
            else if (enableA) m_A <= m_A / 2;
            if (loadResult) m_count <= 0;
            else if (enableResult) m_count <= (m_count < WIDTH) ? m_count + 1 : m_count;
            if ((loadA && enableA) || (!loadResult && enableResult && m_count == WIDTH))
                m_err <= 1;
            m_done_q <= done;
            if (done && !m_done_q) begin
                m_result <= m_count;
                m_valid  <= 1;
                if (m_valid && !rif.result_ack) m_over <= 1;
            end else if (m_valid && rif.result_ack) begin
                m_valid <= 0;
            end
            m_hex <= m_valid ? seg_of(m_result) : 'h7F;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A", A, m_A);
            chk("count", count, m_count);
            chk("result", rif.result, m_result);
            chk("result_valid", rif.result_valid, m_valid);
            chk("overrun", overrun, m_over);
            chk("err", err, m_err);
`ifdef BITCOUNT_HEX_DISPLAY_EN
            chk("HEX0", HEX0, m_hex);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Load operand and shift it out the way the controller would.
    task automatic run_op(input logic [7:0] x, output int shifts);
        loadA = 1; loadResult = 1; data_in = x;
        tick();
        loadA = 0; loadResult = 0;
        shifts = 0;
        while (A != 0 && shifts < 2 * WIDTH) begin
            enableA = 1; enableResult = A[0];
            tick();
            shifts++;
        end
        enableA = 0; enableResult = 0;
        chk("run_bound", A, 0);
    endtask

    task automatic pulse_done(input logic ack);
        done = 1; rif.result_ack = ack;
        tick();
        done = 0; rif.result_ack = 0;
    endtask

    int s;

    initial begin
        reset = 0; data_in = 8'hFF; loadA = 1; enableA = 0;
        loadResult = 0; enableResult = 0; done = 0; rif.result_ack = 0;
        @(posedge clk);
        chk_en = 1;
        tick(); tick();
        chk("rst_A", A, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", rif.result_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_overrun", overrun, 0);
        loadA = 0; reset = 1;
        tick();

        // Normal run 1011_0101: five ones, MSB at bit 7.
        run_op(8'hB5, s);
        chk("shifts_B5", s, 8);
        chk("count_B5", count, 5);
        pulse_done(0);
        chk("result_B5", rif.result, 5);
        chk("valid_B5", rif.result_valid, 1);
        tick();
`ifdef BITCOUNT_HEX_DISPLAY_EN
        chk("hex_5", HEX0, 7'b0010010);
`endif
        rif.result_ack = 1;
        tick();
        rif.result_ack = 0;
        chk("ack_clears", rif.result_valid, 0);
        tick();
`ifdef BITCOUNT_HEX_DISPLAY_EN
        chk("hex_blank", HEX0, 7'b1111111);
`endif

        // Sustained done yields exactly one capture.
        run_op(8'h0F, s);
        chk("shifts_0F", s, 4);
        done = 1;
        tick(); tick();
        chk("held_result", rif.result, 4);
        rif.result_ack = 1;
        tick();
        rif.result_ack = 0;
        tick(); tick();
        chk("held_no_recap", rif.result_valid, 0);
        done = 0;
        tick();

        // Zero operand: no shifts.
        run_op(8'h00, s);
        chk("shifts_00", s, 0);
        pulse_done(0);
        chk("result_00", rif.result, 0);
        chk("valid_00", rif.result_valid, 1);

        // Overrun without ack.
        do_reset();
        run_op(8'h03, s);
        pulse_done(0);
        chk("result_03", rif.result, 2);
        run_op(8'hFF, s);
        pulse_done(0);
        chk("result_FF", rif.result, 8);
        chk("overrun_set", overrun, 1);

        // Capture with simultaneous ack: no overrun.
        do_reset();
        run_op(8'h03, s);
        pulse_done(0);
        run_op(8'hFF, s);
        pulse_done(1);
        chk("ackcap_result", rif.result, 8);
        chk("ackcap_valid", rif.result_valid, 1);
        chk("ackcap_overrun", overrun, 0);

        // loadA beats enableA, flags err.
        do_reset();
        loadA = 1; enableA = 1; data_in = 8'h81;
        tick();
        loadA = 0; enableA = 0;
        chk("prio_A", A, 8'h81);
        chk("prio_err", err, 1);

        // Saturation at WIDTH.
        do_reset();
        loadResult = 1;
        tick();
        loadResult = 0; enableResult = 1;
        repeat (9) tick();
        enableResult = 0;
        chk("sat_count", count, 8);
        chk("sat_err", err, 1);
        loadResult = 1; enableResult = 1;
        tick();
        loadResult = 0; enableResult = 0;
        chk("clr_prio", count, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
